// File: rtl/hyperbus_phy_seq_if.sv
// Signal bundle between a HyperBus transaction source and the PHY sequencer.
// Handshake rule for both trans_* and tx_*: a transfer happens on a rising
// clk_i edge where valid and ready are both high; once valid is raised the
// source keeps it and its payload stable until that edge. rx_valid_i has no
// back-pressure: it is a one-cycle pulse per received word.
interface hyperbus_phy_seq_if #(
    parameter int NumChips   = 2,
    parameter int BurstWidth = 8,
    parameter int LatWidth   = 4
);
    logic                  trans_valid_i;
    logic                  trans_ready_o;
    logic                  trans_write_i;
    logic [NumChips-1:0]   trans_cs_i;
    logic [BurstWidth-1:0] trans_burst_i;
    logic [LatWidth-1:0]   cfg_latency_i;
    logic [LatWidth-1:0]   cfg_recovery_i;
    logic                  rwds_sample_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic                  rx_valid_i;
    logic [NumChips-1:0]   cs_o;
    logic                  cs_ena_o;
    logic                  tx_clk_ena_o;
    logic                  tx_data_oe_o;
    logic                  tx_rwds_oe_o;
    logic                  rwds_sample_ena_o;
    logic                  rx_clk_set_o;
    logic                  rx_clk_reset_o;
    logic                  lat_double_o;
    logic                  done_o;
    logic                  error_o;

    // Sequencer side.
    modport slave (
        input  trans_valid_i, trans_write_i, trans_cs_i, trans_burst_i,
               cfg_latency_i, cfg_recovery_i, rwds_sample_i, tx_valid_i, rx_valid_i,
        output trans_ready_o, tx_ready_o, cs_o, cs_ena_o, tx_clk_ena_o, tx_data_oe_o,
               tx_rwds_oe_o, rwds_sample_ena_o, rx_clk_set_o, rx_clk_reset_o,
               lat_double_o, done_o, error_o
    );

    // Transaction source / transceiver side.
    modport master (
        output trans_valid_i, trans_write_i, trans_cs_i, trans_burst_i,
               cfg_latency_i, cfg_recovery_i, rwds_sample_i, tx_valid_i, rx_valid_i,
        input  trans_ready_o, tx_ready_o, cs_o, cs_ena_o, tx_clk_ena_o, tx_data_oe_o,
               tx_rwds_oe_o, rwds_sample_ena_o, rx_clk_set_o, rx_clk_reset_o,
               lat_double_o, done_o, error_o
    );
endinterface

// File: rtl/hyperbus_phy_seq.sv
// HyperBus PHY sequencer: walks one transaction through chip-select setup,
// 3-cycle command/address, initial latency (single or double, chosen by RWDS
// at the end of CA), the write or read data phase, CS hold and CS-high
// recovery. done_o pulses in the first IDLE cycle after recovery.
// Optional read watchdog: define HYPERBUS_SEQ_TIMEOUT_EN to enable it;
// without it error_o is constant 0 and READ waits indefinitely.
module hyperbus_phy_seq #(
    parameter int NumChips      = 2,
    parameter int BurstWidth    = 8,
    parameter int LatWidth      = 4,
    parameter int TimeoutCycles = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hyperbus_phy_seq_if.slave   bus,
    output logic [2:0]          dbg_state_o
);
    // One counter serves CA, latency, data words and recovery; sized for
    // 2^BurstWidth words and 2*(2^LatWidth-1) latency cycles.
    localparam int CntW  = ((BurstWidth > LatWidth) ? BurstWidth : LatWidth) + 1;
    localparam int TcntW = $clog2(TimeoutCycles + 1);
`ifdef HYPERBUS_SEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CA, S_LATENCY, S_WRITE, S_READ, S_CS_HOLD, S_RECOVER
    } state_t;

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [TcntW-1:0]      tcnt_q;
    logic                  write_q;
    logic [NumChips-1:0]   cs_q;
    logic [BurstWidth-1:0] burst_q;
    logic [LatWidth-1:0]   lat_q, rec_q;
    logic                  lat_double_q, read_first_q, done_q, error_q;

    logic [LatWidth-1:0]   lat_eff, rec_eff;
    logic [CntW-1:0]       lat_len;
    logic                  accept, timeout;

    // Zero-valued latency/recovery settings behave as one cycle.
    assign lat_eff = (lat_q == '0) ? LatWidth'(1) : lat_q;
    assign rec_eff = (rec_q == '0) ? LatWidth'(1) : rec_q;
    assign lat_len = lat_double_q ? CntW'({lat_eff, 1'b0}) : CntW'(lat_eff);
    assign accept  = (state_q == S_IDLE) && bus.trans_valid_i;
    assign timeout = TimeoutEn && (state_q == S_READ) && !bus.rx_valid_i &&
                     (tcnt_q == TcntW'(TimeoutCycles - 1));

    assign bus.lat_double_o = lat_double_q;
    assign bus.done_o       = done_q;
    assign bus.error_o      = TimeoutEn & error_q;
    assign dbg_state_o      = state_q;

    // State, counters and per-transaction latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            write_q      <= 1'b0;
            cs_q         <= '0;
            burst_q      <= '0;
            lat_q        <= '0;
            rec_q        <= '0;
            lat_double_q <= 1'b0;
            read_first_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_first_q <= (state_d == S_READ) && (state_q != S_READ);
            done_q       <= (state_q == S_RECOVER) && (state_d == S_IDLE);
            if (state_q != S_READ || bus.rx_valid_i) tcnt_q <= '0;
            else                                     tcnt_q <= tcnt_q + TcntW'(1);
            if (accept) begin
                write_q      <= bus.trans_write_i;
                cs_q         <= bus.trans_cs_i;
                burst_q      <= bus.trans_burst_i;
                lat_q        <= bus.cfg_latency_i;
                rec_q        <= bus.cfg_recovery_i;
                lat_double_q <= 1'b0;
                error_q      <= 1'b0;
            end
            if (state_q == S_CA && cnt_q == CntW'(2)) lat_double_q <= bus.rwds_sample_i;
            if (timeout) error_q <= 1'b1;
        end
    end

    // Next state and transceiver controls for the current phase.
    always_comb begin
        state_d               = state_q;
        bus.trans_ready_o     = 1'b0;
        bus.tx_ready_o        = 1'b0;
        bus.cs_o              = '0;
        bus.cs_ena_o          = 1'b0;
        bus.tx_clk_ena_o      = 1'b0;
        bus.tx_data_oe_o      = 1'b0;
        bus.tx_rwds_oe_o      = 1'b0;
        bus.rwds_sample_ena_o = 1'b0;
        bus.rx_clk_set_o      = 1'b0;
        bus.rx_clk_reset_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.trans_ready_o = ~rst_i;
                if (bus.trans_valid_i) state_d = S_CS_SETUP;
            end
            S_CS_SETUP: begin
                bus.cs_o     = cs_q;
                bus.cs_ena_o = 1'b1;
                state_d      = S_CA;
            end
            S_CA: begin
                bus.cs_o              = cs_q;
                bus.cs_ena_o          = 1'b1;
                bus.tx_clk_ena_o      = 1'b1;
                bus.tx_data_oe_o      = 1'b1;
                bus.rwds_sample_ena_o = 1'b1;
                if (cnt_q == CntW'(2)) state_d = S_LATENCY;
            end
            S_LATENCY: begin
                bus.cs_o         = cs_q;
                bus.cs_ena_o     = 1'b1;
                bus.tx_clk_ena_o = 1'b1;
                if (cnt_q == lat_len - CntW'(1)) state_d = write_q ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                // The bus clock only runs for cycles that carry a word.
                bus.cs_o         = cs_q;
                bus.cs_ena_o     = 1'b1;
                bus.tx_ready_o   = 1'b1;
                bus.tx_data_oe_o = 1'b1;
                bus.tx_rwds_oe_o = 1'b1;
                bus.tx_clk_ena_o = bus.tx_valid_i;
                if (bus.tx_valid_i && cnt_q == CntW'(burst_q)) state_d = S_CS_HOLD;
            end
            S_READ: begin
                bus.cs_o             = cs_q;
                bus.cs_ena_o         = 1'b1;
                bus.tx_clk_ena_o     = 1'b1;
                bus.rx_clk_set_o     = read_first_q;
                if ((bus.rx_valid_i && cnt_q == CntW'(burst_q)) || timeout) begin
                    bus.rx_clk_reset_o = 1'b1;
                    state_d            = S_CS_HOLD;
                end
            end
            S_CS_HOLD: begin
                bus.cs_o     = cs_q;
                bus.cs_ena_o = 1'b1;
                state_d      = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_q == CntW'(rec_eff) - CntW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter: cleared on every state change, stepped per phase rule.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_CA, S_LATENCY, S_RECOVER: cnt_d = cnt_q + CntW'(1);
                S_WRITE:                    cnt_d = cnt_q + CntW'(bus.tx_valid_i);
                S_READ:                     cnt_d = cnt_q + CntW'(bus.rx_valid_i);
                default:                    cnt_d = cnt_q;
            endcase
        end
    end
endmodule
